// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline boundary register. It captures execute results and owns the
// taken-branch redirect, the wrong-path squash, sticky halt/error and the retire count.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [15:0] ALU_result,
  input  logic        PC_src,
  input  logic [15:0] disp_PC,
  input  logic [15:0] inc_PC,
  input  logic [15:0] st_data,
  input  logic        exe_err,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic        reg_wr_in,
  input  logic        halt_in,
  input  logic [2:0]  wr_reg_in,
  output logic        valid_out,
  output logic [15:0] ALU_result_out,
  output logic [15:0] inc_PC_out,
  output logic [15:0] st_data_out,
  output logic        mem_rd_out,
  output logic        mem_wr_out,
  output logic        reg_wr_out,
  output logic [2:0]  wr_reg_out,
  output logic        redirect,
  output logic [15:0] redirect_PC,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {S_RUN, S_SQUASH, S_HALT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_squash_pend;
  logic        w_halted;
  logic        w_cap;

  logic        r_valid;
  logic [15:0] r_alu;
  logic [15:0] r_inc_pc;
  logic [15:0] r_st_data;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic        r_reg_wr;
  logic [2:0]  r_wr_reg;
  logic        r_redirect;
  logic [15:0] r_redirect_pc;
  logic        r_err;
  logic [15:0] r_retired;

  assign w_squash_pend = (r_state == S_SQUASH);
  assign w_halted      = (r_state == S_HALT);
  assign w_cap         = valid_in & ~flush & ~w_squash_pend & ~w_halted;

  // Halt wins over a simultaneous taken branch; the redirect still pulses below.
  always_comb begin
    w_state_next = r_state;
    if (!stall) begin
      case (r_state)
        S_RUN: begin
          if (w_cap && halt_in)      w_state_next = S_HALT;
          else if (w_cap && PC_src)  w_state_next = S_SQUASH;
        end
        S_SQUASH: w_state_next = S_RUN;
        S_HALT:   w_state_next = S_HALT;
        default:  w_state_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_alu         <= 16'h0000;
      r_inc_pc      <= 16'h0000;
      r_st_data     <= 16'h0000;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_reg_wr      <= 1'b0;
      r_wr_reg      <= 3'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 16'h0000;
      r_err         <= 1'b0;
      r_retired     <= 16'h0000;
    end else if (stall) begin
      r_redirect <= 1'b0;
    end else begin
      r_valid    <= w_cap;
      r_alu      <= ALU_result;
      r_inc_pc   <= inc_PC;
      r_st_data  <= st_data;
      r_mem_rd   <= mem_rd_in & w_cap;
      r_mem_wr   <= mem_wr_in & w_cap;
      r_reg_wr   <= reg_wr_in & w_cap;
      r_wr_reg   <= wr_reg_in;
      r_redirect <= w_cap & PC_src;
      if (w_cap && PC_src) begin
        r_redirect_pc <= disp_PC;
      end
      r_err <= r_err | (w_cap & exe_err);
      if (w_cap && (r_retired != 16'hFFFF)) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign valid_out      = r_valid;
  assign ALU_result_out = r_alu;
  assign inc_PC_out     = r_inc_pc;
  assign st_data_out    = r_st_data;
  assign mem_rd_out     = r_mem_rd;
  assign mem_wr_out     = r_mem_wr;
  assign reg_wr_out     = r_reg_wr;
  assign wr_reg_out     = r_wr_reg;
  assign redirect       = r_redirect;
  assign redirect_PC    = r_redirect_pc;
  assign halted         = w_halted;
  assign err            = r_err;
  assign retired        = r_retired;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized bench for ex_mem_reg against a behavioural model of the capture,
// squash, halt, error and retire rules, plus the directed boundary scenarios.
module tb_ex_mem_reg;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, valid_in, PC_src, exe_err;
  logic        mem_rd_in, mem_wr_in, reg_wr_in, halt_in;
  logic [15:0] ALU_result, disp_PC, inc_PC, st_data;
  logic [2:0]  wr_reg_in;
  logic        valid_out, mem_rd_out, mem_wr_out, reg_wr_out, redirect, halted, err;
  logic [15:0] ALU_result_out, inc_PC_out, st_data_out, redirect_PC, retired;
  logic [2:0]  wr_reg_out;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic        m_valid, m_rd, m_wr, m_rw, m_redir, m_halt, m_err, m_sq;
  logic [15:0] m_alu, m_inc, m_st, m_rpc, m_ret;
  logic [2:0]  m_wreg;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ALU_result(ALU_result), .PC_src(PC_src), .disp_PC(disp_PC), .inc_PC(inc_PC),
    .st_data(st_data), .exe_err(exe_err), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .reg_wr_in(reg_wr_in), .halt_in(halt_in), .wr_reg_in(wr_reg_in),
    .valid_out(valid_out), .ALU_result_out(ALU_result_out), .inc_PC_out(inc_PC_out),
    .st_data_out(st_data_out), .mem_rd_out(mem_rd_out), .mem_wr_out(mem_wr_out),
    .reg_wr_out(reg_wr_out), .wr_reg_out(wr_reg_out), .redirect(redirect),
    .redirect_PC(redirect_PC), .halted(halted), .err(err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_redir = 0; m_halt = 0; m_err = 0; m_sq = 0;
    m_alu = 0; m_inc = 0; m_st = 0; m_rpc = 0; m_ret = 0; m_wreg = 0;
  endtask

  // One clock edge as seen from the pipeline: an instruction either enters MEM or does not.
  task automatic m_edge();
    bit take;
    if (stall) begin
      m_redir = 0;
    end else begin
      take = valid_in && !flush && !m_sq && !m_halt;
      m_valid = take;
      m_alu = ALU_result; m_inc = inc_PC; m_st = st_data; m_wreg = wr_reg_in;
      m_rd = take && mem_rd_in;
      m_wr = take && mem_wr_in;
      m_rw = take && reg_wr_in;
      m_redir = take && PC_src;
      if (take && PC_src) m_rpc = disp_PC;
      m_sq = take && PC_src;
      if (take && halt_in) m_halt = 1;
      if (take && exe_err) m_err = 1;
      if (take && m_ret < 16'hFFFF) m_ret = m_ret + 16'd1;
    end
  endtask

  task automatic check_all();
    check("valid_out",   16'(valid_out),  16'(m_valid));
    check("alu_out",     ALU_result_out,  m_alu);
    check("inc_pc_out",  inc_PC_out,      m_inc);
    check("st_data_out", st_data_out,     m_st);
    check("mem_rd_out",  16'(mem_rd_out), 16'(m_rd));
    check("mem_wr_out",  16'(mem_wr_out), 16'(m_wr));
    check("reg_wr_out",  16'(reg_wr_out), 16'(m_rw));
    check("wr_reg_out",  16'(wr_reg_out), 16'(m_wreg));
    check("redirect",    16'(redirect),   16'(m_redir));
    check("redirect_pc", redirect_PC,     m_rpc);
    check("halted",      16'(halted),     16'(m_halt));
    check("err",         16'(err),        16'(m_err));
    check("retired",     retired,         m_ret);
  endtask

  task automatic cycle();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; valid_in = 0; PC_src = 0; exe_err = 0;
    mem_rd_in = 0; mem_wr_in = 0; reg_wr_in = 0; halt_in = 0;
    ALU_result = 0; disp_PC = 0; inc_PC = 0; st_data = 0; wr_reg_in = 0;
  endtask

  task automatic rand_inputs(input int halt_pct);
    stall      = ($urandom_range(0, 99) < 20);
    flush      = ($urandom_range(0, 99) < 10);
    valid_in   = ($urandom_range(0, 99) < 80);
    PC_src     = ($urandom_range(0, 99) < 25);
    exe_err    = ($urandom_range(0, 99) < 5);
    halt_in    = ($urandom_range(0, 99) < halt_pct);
    mem_rd_in  = 1'($urandom);
    mem_wr_in  = 1'($urandom);
    reg_wr_in  = 1'($urandom);
    ALU_result = 16'($urandom);
    disp_PC    = 16'($urandom);
    inc_PC     = 16'($urandom);
    st_data    = 16'($urandom);
    wr_reg_in  = 3'($urandom);
  endtask

  // Called just after a rising edge; asserts reset between edges with random inputs.
  task automatic async_reset();
    #2;
    rand_inputs(50);
    rst_n = 0;
    m_reset();
    #1;
    check_all();
    #2;
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_reset();
    rst_n = 0;
    #12;
    check_all();
    rst_n = 1;
    valid_in = 1; ALU_result = 16'h1234;
    cycle();
    check("first_valid", 16'(valid_out), 16'h0001);
    check("first_alu", ALU_result_out, 16'h1234);

    // Taken branch, then a wrong-path instruction with reg_wr
    idle_inputs(); valid_in = 1; PC_src = 1; disp_PC = 16'h0040;
    cycle();
    check("br_redirect", 16'(redirect), 16'h0001);
    check("br_target", redirect_PC, 16'h0040);
    check("br_retired", retired, 16'h0002);
    idle_inputs(); valid_in = 1; reg_wr_in = 1;
    cycle();
    check("sq_valid", 16'(valid_out), 16'h0000);
    check("sq_reg_wr", 16'(reg_wr_out), 16'h0000);
    check("sq_redirect", 16'(redirect), 16'h0000);
    check("sq_retired", retired, 16'h0002);

    // Stall during the squash window
    idle_inputs(); valid_in = 1; PC_src = 1; disp_PC = 16'h0080;
    cycle();
    idle_inputs(); stall = 1; valid_in = 1; reg_wr_in = 1; ALU_result = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_redirect", 16'(redirect), 16'h0000);
    end
    stall = 0;
    cycle();
    check("post_stall_squash", 16'(valid_out), 16'h0000);
    cycle();
    check("post_stall_valid", 16'(valid_out), 16'h0001);

    // Flush with a taken branch and a store
    idle_inputs(); valid_in = 1; flush = 1; mem_wr_in = 1; PC_src = 1; disp_PC = 16'h1111;
    cycle();
    check("flush_valid", 16'(valid_out), 16'h0000);
    check("flush_mem_wr", 16'(mem_wr_out), 16'h0000);
    check("flush_redirect", 16'(redirect), 16'h0000);

    // Random traffic without halts, then with halts
    idle_inputs();
    for (int i = 0; i < 800; i++) begin
      rand_inputs(0);
      cycle();
    end
    async_reset();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(3);
      cycle();
    end
    async_reset();

    // Halt together with an error: sticky until reset
    idle_inputs(); valid_in = 1; halt_in = 1; exe_err = 1;
    cycle();
    check("halt_set", 16'(halted), 16'h0001);
    check("err_set", 16'(err), 16'h0001);
    idle_inputs(); valid_in = 1;
    for (int i = 0; i < 4; i++) cycle();
    check("halt_no_valid", 16'(valid_out), 16'h0000);
    check("halt_retired", retired, 16'h0001);
    async_reset();
    check("halt_cleared", 16'(halted), 16'h0000);

    // Saturation of the retire counter
    idle_inputs(); valid_in = 1;
    for (int i = 0; i < 65535 + 5; i++) begin
      ALU_result = 16'(i);
      cycle();
    end
    check("retired_sat", retired, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
